board_store: RTL

BOARD_STORE -- requirements
Module: board_store

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/board_row_full.sv | 14 +
 rtl/board_store.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry, cell coordinate type, lock FSM states and row helpers.
package tetris_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int KIND_W = 4;
    localparam logic [KIND_W-1:0] KIND_EMPTY = '0;
    localparam int ROW_W = BOARD_W * KIND_W;
    localparam logic [KIND_W-1:0] KIND_MAX = 4'd7;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } cell_t;

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, SCAN, SHIFT, DONE} state_t;

    function automatic logic [KIND_W-1:0] row_kind(input logic [ROW_W-1:0] row, input logic [4:0] x);
        return KIND_W'(row >> {x, 2'b00});
    endfunction

    function automatic logic in_board(input cell_t c);
        return c.x < 5'(BOARD_W) && c.y < 5'(BOARD_H);
    endfunction
endpackage

// File: rtl/board_row_full.sv
// board_row_full: flags a board row whose every column holds a non-empty kind.
module board_row_full
    import tetris_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    output logic             full
);
    // Any empty column breaks the row.
    always_comb begin
        full = 1'b1;
        for (int c = 0; c < BOARD_W; c++)
            if (row[c*KIND_W +: KIND_W] == KIND_EMPTY) full = 1'b0;
    end
endmodule

// File: rtl/board_store.sv
// board_store: 10x20 playfield store with overlay read port, lock commit and line clearing.
module board_store
    import tetris_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4:0]          rd_x,
    input  logic [4:0]          rd_y,
    output logic [KIND_W-1:0]   rd_kind,
    input  logic                ovl_en,
    input  logic [KIND_W-1:0]   ovl_kind,
    input  logic [39:0]         ovl_cells,
    input  logic                lock_valid,
    output logic                lock_ready,
    input  logic [KIND_W-1:0]   lock_kind,
    input  logic [39:0]         lock_cells,
    output logic                lock_err,
    output logic                clear_done,
    output logic [2:0]          lines_cleared,
    output logic                busy
);
    state_t state, next;
    logic [ROW_W-1:0] rows [BOARD_H];
    logic [KIND_W-1:0] lk_kind, rd_next;
    cell_t [3:0] lk_cells, ovl_c;
    logic [4:0] r;
    logic [2:0] cnt, cnt_inc;
    logic row_full, above_full, bad, ovl_hit;

    assign ovl_c = ovl_cells;
    assign cnt_inc = (cnt == 3'd4) ? 3'd4 : cnt + 3'd1;

    board_row_full u_row (.row(rows[r]), .full(row_full));
    board_row_full u_above (.row(rows[(r == 5'd0) ? 5'd0 : r - 5'd1]), .full(above_full));

    // Reject a lock with a bad kind, an off-board cell or an occupied target.
    always_comb begin
        bad = lk_kind == KIND_EMPTY || lk_kind > KIND_MAX;
        for (int i = 0; i < 4; i++)
            if (!in_board(lk_cells[i])) bad = 1'b1;
            else if (row_kind(rows[lk_cells[i].y], lk_cells[i].x) != KIND_EMPTY) bad = 1'b1;
    end

    // Read lookup: off-board gives empty, overlay wins over the stored kind.
    always_comb begin
        ovl_hit = 1'b0;
        for (int i = 0; i < 4; i++)
            if (ovl_c[i] == {rd_x, rd_y}) ovl_hit = 1'b1;
        rd_next = KIND_EMPTY;
        if (rd_x < 5'(BOARD_W) && rd_y < 5'(BOARD_H))
            rd_next = (ovl_en && ovl_hit) ? ovl_kind : row_kind(rows[rd_y], rd_x);
    end

    // Next state and FSM outputs; SHIFT looks ahead at the row that drops into r.
    always_comb begin
        next = state;
        lock_ready = 1'b0;
        lock_err = 1'b0;
        clear_done = 1'b0;
        busy = state != IDLE;
        case (state)
            IDLE: begin
                lock_ready = 1'b1;
                next = lock_valid ? CHECK : IDLE;
            end
            CHECK: begin
                lock_err = bad;
                next = bad ? IDLE : WRITE;
            end
            WRITE: next = SCAN;
            SCAN: next = row_full ? SHIFT : (r == 5'd0) ? DONE : SCAN;
            SHIFT: next = (r == 5'd0) ? DONE : above_full ? SHIFT : SCAN;
            DONE: begin
                clear_done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next;
    end

    // Board rows: four-cell commit in WRITE, collapse rows r..1 downward in SHIFT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < BOARD_H; k++) rows[k] <= '0;
        end else if (state == WRITE) begin
            for (int k = 0; k < BOARD_H; k++)
                for (int c = 0; c < BOARD_W; c++)
                    for (int i = 0; i < 4; i++)
                        if (lk_cells[i] == {5'(c), 5'(k)}) rows[k][c*KIND_W +: KIND_W] <= lk_kind;
        end else if (state == SHIFT) begin
            for (int k = 1; k < BOARD_H; k++)
                if (5'(k) <= r) rows[k] <= rows[k-1];
            rows[0] <= '0;
        end
    end

    // Lock capture, scan row, line counter, result and read registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lk_kind <= '0;
            lk_cells <= '0;
            r <= '0;
            cnt <= '0;
            lines_cleared <= '0;
            rd_kind <= '0;
        end else begin
            rd_kind <= rd_next;
            if (state == IDLE && lock_valid) begin
                lk_kind <= lock_kind;
                lk_cells <= lock_cells;
            end
            if (state == WRITE) begin
                r <= 5'(BOARD_H - 1);
                cnt <= '0;
            end
            if (state == SCAN && !row_full && r != 5'd0) r <= r - 5'd1;
            if (state == SHIFT) begin
                cnt <= cnt_inc;
                if (r != 5'd0 && !above_full) r <= r - 5'd1;
            end
            if (next == DONE) lines_cleared <= (state == SHIFT) ? cnt_inc : cnt;
        end
    end
endmodule
